vga_sprite_overlay: RTL and testbench
=====================================

Name: vga_sprite_overlay

Overview:
- Stage directly downstream of the VGA timing generator and the picture generator, feeding the VGA connector.
- Consumes hst/vst, hsync/vsync and background rgb; overlays a solid square sprite that bounces off the visible-area edges, moving once per frame.
- Outputs are re-registered so that sync and colour leave the block aligned with the same pixel.

Parameters:
- H_VIS, 800, visible pixels per line (visible when hst < H_VIS)
- V_VIS, 600, visible lines per frame (visible when vst < V_VIS)
- BOX_SZ, 64, sprite width and height in pixels
- BOX_COLOR, 3'b111, sprite colour {R,G,B}

Ports:
- clk50  in  1  pixel clock, 50 MHz
- rst  in  1  asynchronous reset, active-high
- hst  in  11  horizontal pixel counter from the timing generator
- vst  in  10  vertical line counter from the timing generator
- hsync_in  in  1  hsync from the timing generator
- vsync_in  in  1  vsync from the timing generator
- rgb_in  in  3  background colour from the picture generator, same pixel as hst/vst
- enable  in  1  1 = draw and move the sprite; 0 = pass the background through and freeze the position
- speed  in  4  pixels moved per frame on each axis; 0 = frozen
- hsync  out  1  hsync delayed by 2 clocks
- vsync  out  1  vsync delayed by 2 clocks
- rgb  out  3  final pixel colour, delayed by 2 clocks
- bounce  out  1  one-clock pulse when any edge reflection occurs

Behaviour:
- Reset (asynchronous, active-high):
  - Outputs hsync, vsync, rgb and bounce are 0.
  - Sprite state is x=0, y=0, dir_x=right, dir_y=down; the pipeline registers are cleared.
- Pipeline (2 stages, fixed 2-clock latency for hsync, vsync and rgb, independent of enable):
  - S1 registers hsync_in, vsync_in and rgb_in. It also registers vis = (hst<H_VIS)&&(vst<V_VIS) and hit = enable && x<=hst<x+BOX_SZ && y<=vst<y+BOX_SZ.
  - S2 produces rgb = !vis ? 0 : hit ? color : rgb_in_d, and registers the syncs.
- Compare arithmetic: widths are 12 bits so x+BOX_SZ cannot overflow.
- Position update:
  - Fires once per frame, on the clock where hst==H_VIS && vst==V_VIS-1 (end of the last visible line). The position never changes while a visible pixel is being drawn.
  - It is skipped when enable==0 or speed==0.
- X axis, moving right:
  - If x+speed >= H_VIS-BOX_SZ: x <= H_VIS-BOX_SZ, dir_x <= left, bounce event.
  - Otherwise x <= x+speed.
- X axis, moving left:
  - If x <= speed: x <= 0, dir_x <= right, bounce event.
  - Otherwise x <= x-speed.
- Y axis: same rules using V_VIS, y, dir_y (down/up).
- Landing exactly on the limit counts as a bounce. Simultaneous X and Y bounces (corner) produce a single bounce pulse.
- bounce: asserted the clock after the update event, for 1 clock.
- Boundary conditions:
  - enable changing mid-frame takes effect on the next S1 sample (2-clock output latency).
  - Reset mid-frame restarts from x=0, y=0 at the next update event.
  - Sprite pixels outside the visible area are blanked (rgb=0), as is the rest of the blanking interval.

Optional Feature:
- Macro: VGA_SPRITE_COLOR_CYCLE_EN.
- Defined: color is a 3-bit register, reset to BOX_COLOR, that increments modulo 8 on every bounce event. When the increment would produce 3'b000, the value 3'b001 is used instead, so the sprite never turns black.
- Undefined: color is constantly BOX_COLOR; no register is built.

Test Plan:
- Latency and pass-through: after reset, enable=0, drive hst=100, vst=100, rgb_in=3'b101 → 2 clocks later rgb=3'b101; a pulse on hsync_in appears on hsync exactly 2 clocks later.
- Sprite hit: enable=1, position (0,0), hst=10, vst=10, rgb_in=3'b010 → rgb=3'b111 after 2 clocks; at hst=64, vst=10 → rgb=3'b010.
- Blanking: hst=900, vst=10, rgb_in=3'b101 → rgb=0. Also hst=10, vst=620 → rgb=0.
- Motion: speed=4, run one full frame (1040×666 clocks) → position (4,4). A sprite pixel at hst=4, vst=4 is drawn; hst=3, vst=4 shows the background.
- X bounce: force x=732, dir right, speed=8 → next update gives x=736, dir_x=left, bounce=1 for one clock. The next frame gives x=728. Y bounce at 536 behaves the same way.
- Reset mid-frame with x=300: assert rst → outputs 0 immediately. After release, the first update moves the sprite to (speed, speed). With VGA_SPRITE_COLOR_CYCLE_EN defined, the colour sequence across bounces is 111→001→010.

Source files
------------

// File: rtl/vga_sprite_overlay.sv
// vga_sprite_overlay: overlays a bouncing solid square sprite on the background
// picture. Sync and colour leave the block through a fixed 2-clock pipeline.
// The sprite position advances once per frame, at the end of the last visible line.
// Optional build macro VGA_SPRITE_COLOR_CYCLE_EN: when defined, the sprite colour
// steps on every bounce and never becomes black.
module vga_sprite_overlay #(
    parameter int         H_VIS     = 800,
    parameter int         V_VIS     = 600,
    parameter int         BOX_SZ    = 64,
    parameter logic [2:0] BOX_COLOR = 3'b111
) (
    input  logic        clk50,
    input  logic        rst,
    input  logic [10:0] hst,
    input  logic [9:0]  vst,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic [2:0]  rgb_in,
    input  logic        enable,
    input  logic [3:0]  speed,
    output logic        hsync,
    output logic        vsync,
    output logic [2:0]  rgb,
    output logic        bounce
);

    // 12-bit compare arithmetic so that position + BOX_SZ cannot wrap
    localparam logic [11:0] H_VIS12 = 12'(H_VIS);
    localparam logic [11:0] V_VIS12 = 12'(V_VIS);
    localparam logic [11:0] BOX12   = 12'(BOX_SZ);
    localparam logic [11:0] H_LIM   = 12'(H_VIS - BOX_SZ);
    localparam logic [11:0] V_LIM   = 12'(V_VIS - BOX_SZ);

    // Sprite state: dir = 0 means right/down, 1 means left/up
    logic [11:0] x;
    logic [11:0] y;
    logic        dir_x;
    logic        dir_y;

    logic [11:0] hst_w;
    logic [11:0] vst_w;
    logic [11:0] spd;
    logic        vis_c;
    logic        hit_c;
    logic        upd;
    logic [13:0] step_x;
    logic [13:0] step_y;

    // Pipeline stage 1 registers
    logic        hsync_p1;
    logic        vsync_p1;
    logic [2:0]  rgb_p1;
    logic        vis_p1;
    logic        hit_p1;

    // One axis step with reflection: returns {bounced, new_dir, new_pos}.
    // Landing exactly on a limit is reported as a bounce.
    function automatic logic [13:0] step_axis(input logic [11:0] pos,
                                              input logic        dir,
                                              input logic [11:0] step,
                                              input logic [11:0] lim);
        logic [13:0] r;
        if (!dir) begin
            if (pos + step >= lim) r = {1'b1, 1'b1, lim};
            else                   r = {1'b0, 1'b0, 12'(pos + step)};
        end else begin
            if (pos <= step) r = {1'b1, 1'b0, 12'd0};
            else             r = {1'b0, 1'b1, 12'(pos - step)};
        end
        return r;
    endfunction

    assign hst_w = {1'b0, hst};
    assign vst_w = {2'b00, vst};
    assign spd   = {8'd0, speed};

    assign vis_c = (hst_w < H_VIS12) && (vst_w < V_VIS12);
    assign hit_c = enable &&
                   (hst_w >= x) && (hst_w < x + BOX12) &&
                   (vst_w >= y) && (vst_w < y + BOX12);

    // Update point lies in horizontal blanking, so no visible pixel sees a moving sprite
    assign upd = enable && (speed != 4'd0) &&
                 (hst_w == H_VIS12) && (vst_w == V_VIS12 - 12'd1);

    assign step_x = step_axis(x, dir_x, spd, H_LIM);
    assign step_y = step_axis(y, dir_y, spd, V_LIM);

    // Per-frame position update; a corner hit still yields a single bounce pulse
    always_ff @(posedge clk50 or posedge rst) begin
        if (rst) begin
            x      <= 12'd0;
            y      <= 12'd0;
            dir_x  <= 1'b0;
            dir_y  <= 1'b0;
            bounce <= 1'b0;
        end else if (upd) begin
            x      <= step_x[11:0];
            dir_x  <= step_x[12];
            y      <= step_y[11:0];
            dir_y  <= step_y[12];
            bounce <= step_x[13] | step_y[13];
        end else begin
            bounce <= 1'b0;
        end
    end

`ifdef VGA_SPRITE_COLOR_CYCLE_EN
    logic [2:0] color;

    // Advance the sprite colour on each bounce, skipping black
    always_ff @(posedge clk50 or posedge rst) begin
        if (rst) begin
            color <= BOX_COLOR;
        end else if (upd && (step_x[13] || step_y[13])) begin
            color <= (color == 3'b111) ? 3'b001 : color + 3'd1;
        end
    end
`else
    logic [2:0] color;
    assign color = BOX_COLOR;
`endif

    // Stage 1: capture syncs, background and the visibility/hit decisions
    always_ff @(posedge clk50 or posedge rst) begin
        if (rst) begin
            hsync_p1 <= 1'b0;
            vsync_p1 <= 1'b0;
            rgb_p1   <= 3'd0;
            vis_p1   <= 1'b0;
            hit_p1   <= 1'b0;
        end else begin
            hsync_p1 <= hsync_in;
            vsync_p1 <= vsync_in;
            rgb_p1   <= rgb_in;
            vis_p1   <= vis_c;
            hit_p1   <= hit_c;
        end
    end

    // Stage 2: select final colour and realign syncs with it
    always_ff @(posedge clk50 or posedge rst) begin
        if (rst) begin
            hsync <= 1'b0;
            vsync <= 1'b0;
            rgb   <= 3'd0;
        end else begin
            hsync <= hsync_p1;
            vsync <= vsync_p1;
            rgb   <= !vis_p1 ? 3'd0 : (hit_p1 ? color : rgb_p1);
        end
    end

endmodule

// File: tb/tb_vga_sprite_overlay.sv
// Testbench for vga_sprite_overlay: a driver pushes the expected response of
// every driven pixel into a queue; a monitor pops it and compares once the
// DUT output for that pixel is present (bounce after 1 clock, rgb/syncs after 2).
module tb_vga_sprite_overlay;

    logic        clk50 = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] hst = '0;
    logic [9:0]  vst = '0;
    logic        hsync_in = 1'b0;
    logic        vsync_in = 1'b0;
    logic [2:0]  rgb_in = '0;
    logic        enable = 1'b0;
    logic [3:0]  speed = '0;
    logic        hsync;
    logic        vsync;
    logic [2:0]  rgb;
    logic        bounce;

    vga_sprite_overlay dut (
        .clk50    (clk50),
        .rst      (rst),
        .hst      (hst),
        .vst      (vst),
        .hsync_in (hsync_in),
        .vsync_in (vsync_in),
        .rgb_in   (rgb_in),
        .enable   (enable),
        .speed    (speed),
        .hsync    (hsync),
        .vsync    (vsync),
        .rgb      (rgb),
        .bounce   (bounce)
    );

    always #5 clk50 = ~clk50;

    typedef struct {
        logic       chk;
        logic       hs;
        logic       vs;
        logic [2:0] rgb;
        logic       b;
        int         id;
    } exp_t;

    exp_t       q[$];
    int         passed = 0;
    int         total = 0;
    int         sid = 0;
    logic       cfg_en = 1'b0;
    logic [3:0] cfg_spd = 4'd0;
    logic [2:0] col = 3'b111;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act == req) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    // Drive one pixel at the falling edge and queue its expected response
    task automatic drive(input int h, input int v, input logic hs, input logic vs,
                         input logic [2:0] rin, input logic [2:0] erg,
                         input logic eb, input logic chk);
        exp_t e;
        @(negedge clk50);
        rst      = 1'b0;
        enable   = cfg_en;
        speed    = cfg_spd;
        hst      = 11'(h);
        vst      = 10'(v);
        hsync_in = hs;
        vsync_in = vs;
        rgb_in   = rin;
        e.chk = chk; e.hs = hs; e.vs = vs; e.rgb = erg; e.b = eb; e.id = sid;
        sid++;
        q.push_back(e);
    endtask

    task automatic probe(input int h, input int v, input logic [2:0] rin, input logic [2:0] erg);
        drive(h, v, 1'b0, 1'b0, rin, erg, 1'b0, 1'b1);
    endtask

    task automatic frame_update(input logic eb);
        drive(800, 599, 1'b0, 1'b0, 3'b000, 3'b000, eb, 1'b1);
    endtask

    // Monitor: bounce of the newest pixel, rgb/syncs of the one before it
    exp_t held;
    logic held_v = 1'b0;
    always @(posedge clk50) begin
        #1;
        if (held_v && held.chk) begin
            check($sformatf("rgb#%0d", held.id), rgb, held.rgb);
            check($sformatf("hsync#%0d", held.id), hsync, held.hs);
            check($sformatf("vsync#%0d", held.id), vsync, held.vs);
        end
        if (q.size() > 0) begin
            held = q.pop_front();
            held_v = 1'b1;
            check($sformatf("bounce#%0d", held.id), bounce, held.b);
        end else begin
            held_v = 1'b0;
        end
    end

    initial begin
        exp_t e;
        // Reset state
        @(negedge clk50);
        #1;
        check("rst_rgb", rgb, 0);
        check("rst_hsync", hsync, 0);
        check("rst_vsync", vsync, 0);
        check("rst_bounce", bounce, 0);

        // Pass-through with sprite disabled, sync pulses at 2-clock latency
        cfg_en = 1'b0; cfg_spd = 4'd0;
        drive(100, 100, 1'b0, 1'b0, 3'b101, 3'b101, 1'b0, 1'b1);
        drive(100, 100, 1'b1, 1'b0, 3'b101, 3'b101, 1'b0, 1'b1);
        drive(100, 100, 1'b0, 1'b1, 3'b011, 3'b011, 1'b0, 1'b1);
        drive(100, 100, 1'b0, 1'b0, 3'b011, 3'b011, 1'b0, 1'b1);
        probe(10, 10, 3'b010, 3'b010);

        // Sprite hit at (0,0)
        cfg_en = 1'b1;
        probe(10, 10, 3'b010, col);
        probe(64, 10, 3'b010, 3'b010);
        probe(63, 63, 3'b100, col);
        probe(63, 64, 3'b100, 3'b100);
        probe(0, 0, 3'b001, col);

        // Blanking
        probe(900, 10, 3'b101, 3'b000);
        probe(10, 620, 3'b101, 3'b000);
        probe(800, 10, 3'b101, 3'b000);
        probe(799, 10, 3'b101, 3'b101);

        // One frame of motion at speed 4 -> (4,4)
        cfg_spd = 4'd4;
        frame_update(1'b0);
        probe(4, 4, 3'b010, col);
        probe(3, 4, 3'b010, 3'b010);
        probe(4, 3, 3'b010, 3'b010);
        probe(67, 67, 3'b010, col);
        probe(68, 67, 3'b010, 3'b010);

        // Update skipped when disabled or speed is zero
        cfg_en = 1'b0;
        frame_update(1'b0);
        cfg_en = 1'b1; cfg_spd = 4'd0;
        frame_update(1'b0);
        probe(4, 4, 3'b010, col);
        probe(3, 4, 3'b010, 3'b010);

        // Speed 12: y lands past 536 on update 45 -> y=536, up, bounce
        cfg_spd = 4'd12;
        for (int k = 1; k <= 45; k++) frame_update(k == 45);
`ifdef VGA_SPRITE_COLOR_CYCLE_EN
        col = 3'b001;
`endif
        probe(544, 536, 3'b011, col);
        probe(543, 536, 3'b011, 3'b011);
        probe(544, 535, 3'b011, 3'b011);

        // x lands exactly on 736 on update 61 -> left, bounce; y=344
        for (int k = 46; k <= 61; k++) frame_update(k == 61);
`ifdef VGA_SPRITE_COLOR_CYCLE_EN
        col = 3'b010;
`endif
        probe(736, 344, 3'b100, col);
        probe(735, 344, 3'b100, 3'b100);
        probe(736, 343, 3'b100, 3'b100);
        probe(799, 407, 3'b100, col);

        // Moving left at speed 8 -> (728,336), no bounce
        cfg_spd = 4'd8;
        frame_update(1'b0);
        probe(728, 336, 3'b010, col);
        probe(727, 336, 3'b010, 3'b010);

        // Reset mid-frame while outputs are non-zero
        drive(728, 336, 1'b1, 1'b1, 3'b010, col, 1'b0, 1'b1);
        drive(728, 336, 1'b1, 1'b1, 3'b010, col, 1'b0, 1'b1);
        drive(728, 336, 1'b1, 1'b1, 3'b010, col, 1'b0, 1'b0);
        @(negedge clk50);
        rst = 1'b1;
        hst = 11'd900; vst = 10'd10; hsync_in = 1'b0; vsync_in = 1'b0; rgb_in = 3'b000;
        e.chk = 1'b0; e.hs = 1'b0; e.vs = 1'b0; e.rgb = 3'b000; e.b = 1'b0; e.id = sid;
        sid++;
        q.push_back(e);
        #1;
        check("midrst_rgb", rgb, 0);
        check("midrst_hsync", hsync, 0);
        check("midrst_vsync", vsync, 0);
        check("midrst_bounce", bounce, 0);
        col = 3'b111;

        // First update after reset moves to (8,8)
        probe(900, 10, 3'b101, 3'b000);
        frame_update(1'b0);
        probe(8, 8, 3'b110, col);
        probe(7, 8, 3'b110, 3'b110);
        probe(8, 7, 3'b110, 3'b110);

        // Flush
        probe(900, 10, 3'b000, 3'b000);
        probe(900, 10, 3'b000, 3'b000);
        probe(900, 10, 3'b000, 3'b000);
        repeat (3) @(posedge clk50);
        #2;
        check("queue_drained", q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
